// File: rtl/cache_defs.sv
// Shared cache definitions.
// Holds the refill controller state encoding so that the controller and any
// checker bound to its debug state output agree on the same values.
package cache_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DRAIN  = 2'd2
  } type_icache_refill_states_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Counts increment pulses and sticks at all-ones instead of wrapping.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - synchronous active-low reset, clears the count
//   inc_i  - increment by one this cycle (ignored once saturated)
//   clr_i  - synchronous clear, has priority over inc_i
//   cnt_o  - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache refill controller.
// Acknowledges fetch hits one cycle later and, on a miss, requests a full
// line from memory, writing each delivered beat into the data array and
// marking the line valid with the last beat. A fetch redirect (kill) or a
// move out of the cacheable region abandons the line: memory cannot abort,
// so the remaining beats are drained without being written.
//
// Handshake: icache2mem_req_o is a level request held from the miss until
// the last beat; each cycle with mem2icache_ack_i high delivers exactly one
// beat. There is no back-pressure on beats; acks outside a refill/drain are
// ignored.
//
// Ports:
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   cache_hit_i            - tag match for the current fetch address
//   imem_sel_i             - fetch address is cacheable
//   if2icache_req_i        - fetch request
//   if2icache_req_kill_i   - fetch redirect, abandon the current miss
//   icache2if_ack_o        - registered fetch acknowledge
//   cache_wr_o             - write the current beat into the data array
//   cache_beat_idx_o       - word index of the beat being written
//   cache_line_valid_o     - set line valid (only with the last beat write)
//   mem2icache_ack_i       - one memory beat delivered this cycle
//   icache2mem_req_o       - line read request to memory
//   busy_o                 - controller not idle
//   miss_cnt_o, kill_cnt_o - saturating refill-started / refill-killed counts
//   dbg_state_o            - current FSM state (cache_defs encoding)
module icache_refill_ctrl
  import cache_defs::*;
#(
  parameter int BEATS = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cache_hit_i,
  input  logic                     imem_sel_i,
  input  logic                     if2icache_req_i,
  input  logic                     if2icache_req_kill_i,
  output logic                     icache2if_ack_o,
  output logic                     cache_wr_o,
  output logic [$clog2(BEATS)-1:0] cache_beat_idx_o,
  output logic                     cache_line_valid_o,
  input  logic                     mem2icache_ack_i,
  output logic                     icache2mem_req_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         miss_cnt_o,
  output logic [CNT_W-1:0]         kill_cnt_o,
  output logic [1:0]               dbg_state_o
);

  localparam int IDX_W = $clog2(BEATS);

  type_icache_refill_states_e r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ack;

  logic w_hit, w_miss, w_abandon, w_last;
  logic w_mem_req, w_wr, w_line_valid, w_miss_inc, w_kill_inc;

  assign w_hit     = if2icache_req_i & imem_sel_i & cache_hit_i;
  assign w_miss    = if2icache_req_i & imem_sel_i & ~cache_hit_i;
  assign w_abandon = if2icache_req_kill_i | ~imem_sel_i;
  assign w_last    = (r_cnt == IDX_W'(BEATS - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mem_req    = 1'b0;
    w_wr         = 1'b0;
    w_line_valid = 1'b0;
    w_miss_inc   = 1'b0;
    w_kill_inc   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_miss && !if2icache_req_kill_i) begin
          w_mem_req   = 1'b1;
          w_cnt_nxt   = '0;
          w_miss_inc  = 1'b1;
          w_state_nxt = REFILL;
        end
      end

      REFILL: begin
        w_mem_req = 1'b1;
        if (w_abandon) begin
          w_kill_inc  = 1'b1;
          w_state_nxt = DRAIN;
          // The beat arriving with the kill is consumed but not written.
          // If it was the last one the line is already complete on the
          // memory side, so there is nothing left to drain.
          if (mem2icache_ack_i) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_last) w_state_nxt = IDLE;
          end
        end else if (mem2icache_ack_i) begin
          w_wr      = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) begin
            w_line_valid = 1'b1;
            w_state_nxt  = IDLE;
          end
        end
      end

      DRAIN: begin
        // Kill / select changes are deliberately ignored here: the memory
        // keeps delivering until the line is done.
        w_mem_req = 1'b1;
        if (mem2icache_ack_i) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    // Combinational outputs are forced quiet while reset is held so a
    // refill interrupted by reset can never mark a line valid.
    if (!rst_ni) begin
      w_state_nxt  = IDLE;
      w_cnt_nxt    = '0;
      w_mem_req    = 1'b0;
      w_wr         = 1'b0;
      w_line_valid = 1'b0;
      w_miss_inc   = 1'b0;
      w_kill_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Hits are only acknowledged from IDLE, so the ack is low for every
      // cycle spent in REFILL or DRAIN.
      r_ack   <= (r_state == IDLE) & w_hit;
    end
  end

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_miss_inc),
    .clr_i  (1'b0),
    .cnt_o  (miss_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_kill_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_kill_inc),
    .clr_i  (1'b0),
    .cnt_o  (kill_cnt_o)
  );

  assign icache2if_ack_o    = r_ack;
  assign icache2mem_req_o   = w_mem_req;
  assign cache_wr_o         = w_wr;
  assign cache_beat_idx_o   = w_wr ? r_cnt : '0;
  assign cache_line_valid_o = w_line_valid;
  assign busy_o             = rst_ni & (r_state != IDLE);
  assign dbg_state_o        = r_state;

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter BEATS, default 4: memory beats per cache line; power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default 16: width of miss and kill statistics counters.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cache_hit_i  input  1  tag match for the current fetch address.
REQ-006 SHALL have port imem_sel_i  input  1  fetch address lies in the cacheable region.
REQ-007 SHALL have port if2icache_req_i  input  1  fetch request.
REQ-008 SHALL have port if2icache_req_kill_i  input  1  fetch redirect; abandon the current miss.
REQ-009 SHALL have port icache2if_ack_o  output  1  registered fetch acknowledge.
REQ-010 SHALL have port cache_wr_o  output  1  write the current beat into the data array.
REQ-011 SHALL have port cache_beat_idx_o  output  $clog2(BEATS)  word index of the beat being written.
REQ-012 SHALL have port cache_line_valid_o  output  1  set the line valid bit; asserted only with the last beat write.
REQ-013 SHALL have port mem2icache_ack_i  input  1  one memory beat delivered this cycle.
REQ-014 SHALL have port icache2mem_req_o  output  1  line read request to memory.
REQ-015 SHALL have port busy_o  output  1  controller is not in IDLE.
REQ-016 SHALL have port miss_cnt_o  output  CNT_W  number of refills started.
REQ-017 SHALL have port kill_cnt_o  output  CNT_W  number of refills abandoned by a kill.

Function
REQ-018 SHALL define hit = if2icache_req_i & imem_sel_i & cache_hit_i, and miss = if2icache_req_i & imem_sel_i & ~cache_hit_i.
REQ-019 SHALL register icache2if_ack_o as hit, one cycle after the hit; it SHALL be 0 while in REFILL or DRAIN.
REQ-020 SHALL implement states IDLE, REFILL and DRAIN.
REQ-021 SHALL, in IDLE, on miss & ~kill, assert icache2mem_req_o combinationally, clear the beat counter, increment miss_cnt_o and go to REFILL.
REQ-022 SHALL, in REFILL, hold icache2mem_req_o high until the last beat ack; memory does not support abort.
REQ-023 SHALL, in REFILL with ack and no kill, assert cache_wr_o with cache_beat_idx_o = beat counter, then increment the counter.
REQ-024 SHALL, on the ack whose counter equals BEATS-1, also assert cache_line_valid_o and return to IDLE.
REQ-025 SHALL, in REFILL with kill or ~imem_sel_i, go to DRAIN and increment kill_cnt_o; an ack in that same cycle SHALL be counted but SHALL NOT be written.
REQ-026 SHALL, in DRAIN, keep icache2mem_req_o high, consume acks with cache_wr_o = 0, and go to IDLE on the last beat ack.
REQ-027 SHALL NOT start a new refill before DRAIN completes; kill and imem_sel_i changes SHALL NOT shorten DRAIN.
REQ-028 SHALL count beats modulo BEATS with no overflow; an ack in IDLE SHALL be ignored.
REQ-029 SHALL make the counters saturate at all-ones, not wrap.
REQ-030 SHALL, after a successful refill, let the re-issued fetch hit in IDLE, giving an ack the following cycle.

Reset
REQ-031 SHALL, with rst_ni low at a clock edge, set the state to IDLE, the beat counter to 0, icache2if_ack_o to 0 and both counters to 0.
REQ-032 SHALL drive all combinational outputs to 0 while in reset; reset during REFILL abandons the line with no valid write.

Structure
REQ-033 SHALL place the type_icache_refill_states_e enum (IDLE, REFILL, DRAIN) in the shared cache_defs package.
REQ-034 SHALL implement the saturating counter as the sub-module sat_counter (parameter W, inputs inc and clr), instantiated twice.

Verification
REQ-035 SHALL test a hit: req=sel=hit=1 in cycle t -> icache2if_ack_o=1 in t+1, and no memory request.
REQ-036 SHALL test a full refill with BEATS=4: a miss, then acks in 4 non-consecutive cycles -> cache_wr_o with idx 0,1,2,3, cache_line_valid_o only with idx 3, miss_cnt_o=1.
REQ-037 SHALL test a kill after 1 beat: the kill in REFILL -> DRAIN, 3 further acks with no cache_wr_o, and kill_cnt_o=1.
REQ-038 SHALL test a miss during DRAIN: icache2mem_req_o stays asserted for the drained line, and the new refill starts only the cycle after the last drain ack.
REQ-039 SHALL test reset mid-REFILL at beat 2: all outputs and counters are 0 next cycle, and a later stray ack produces no write.
REQ-040 SHALL test saturation with CNT_W=2: 5 misses -> miss_cnt_o=3.
